// File: rtl/mel_pkg.sv
// Shared definitions for the MEL front end: frame-index width, ring sizing helpers
// and the framing FSM state encoding reused by the window and FFT stages.
package mel_pkg;

  localparam int FW = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } frame_state_t;

  // Ring depth: smallest power of two that holds one window plus one hop.
  function automatic int calc_depth(input int win, input int hop);
    return 1 << $clog2(win + hop);
  endfunction

  // Count width: must represent 0..depth inclusive.
  function automatic int calc_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_ram.sv
// Simple dual-port sample store: synchronous write, registered read that holds its
// value while re is low. No reset on the array so it maps onto block RAM.
module ring_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_ring_buffer.sv
// Overlapping frame generator: buffers a sample stream in a power-of-two ring and
// emits WIN_LENGTH-sample frames advancing by HOP_LENGTH, with flush/zero-pad drain.
module frame_ring_buffer
  import mel_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int WIN_LENGTH = 480,
  parameter  int HOP_LENGTH = 160,
  localparam int DEPTH      = calc_depth(WIN_LENGTH, HOP_LENGTH),
  localparam int CW         = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic [FW-1:0]    frm_idx,
  input  logic             flush,
  output logic             flush_done,
  output logic [CW-1:0]    count
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] WIN_C     = CW'(WIN_LENGTH);
  localparam logic [CW-1:0] HOP_C     = CW'(HOP_LENGTH);
  localparam logic [CW-1:0] FLUSH_MIN = CW'(WIN_LENGTH - HOP_LENGTH);
  localparam logic [CW-1:0] LAST_OFF  = CW'(WIN_LENGTH - 1);

  // Handshakes: a transfer happens on a port in any cycle where valid and ready are
  // both high at the rising clock edge; m_* hold stable while m_valid & ~m_ready.

  frame_state_t state, state_n;
  logic [AW-1:0] wr_ptr, wr_n, base_ptr, base_n;
  logic [CW-1:0] rd_off, rd_off_n, count_n, issue_off;
  logic [CW-1:0] cnt_wr, cnt_hop, cnt_after;
  logic [FW-1:0] frm_n;
  logic          issued_all, issued_all_n, flushing, flushing_n;
  logic          wr_fire, pop, eof_fire, next_go, issue;
  logic          o_valid, o_sof, o_eof, o_zero;
  logic [WIDTH-1:0] ram_q;

  assign s_ready   = (count < DEPTH_C) && !flushing;
  assign wr_fire   = s_valid && s_ready;
  assign pop       = o_valid && m_ready;
  assign eof_fire  = pop && o_eof;
  assign cnt_wr    = count + CW'(wr_fire);
  assign cnt_hop   = (count > HOP_C) ? count - HOP_C : '0;
  assign cnt_after = cnt_hop + CW'(wr_fire);
  assign next_go   = (cnt_after >= WIN_C) || (flushing && (cnt_after > FLUSH_MIN));

  always_comb begin
    state_n      = state;
    wr_n         = wr_fire ? wr_ptr + AW'(1) : wr_ptr;
    base_n       = base_ptr;
    count_n      = cnt_wr;
    frm_n        = frm_idx;
    rd_off_n     = rd_off;
    issued_all_n = issued_all;
    flushing_n   = flushing || flush;
    issue        = 1'b0;
    issue_off    = rd_off;
    case (state)
      FILL: begin
        if ((count >= WIN_C) || (flushing && (count > FLUSH_MIN))) begin
          state_n      = EMIT;
          rd_off_n     = '0;
          issued_all_n = 1'b0;
        end else if (flushing) begin
          state_n = DONE;
        end
      end
      EMIT: begin
        if (eof_fire) begin
          base_n       = base_ptr + AW'(HOP_LENGTH);
          count_n      = cnt_after;
          frm_n        = frm_idx + FW'(1);
          rd_off_n     = '0;
          issued_all_n = 1'b0;
          // Launch the next frame's first read on the eof edge so sof follows eof directly.
          if (next_go) begin
            issue     = 1'b1;
            issue_off = '0;
            rd_off_n  = CW'(1);
          end else begin
            state_n = FILL;
          end
        end else if (!issued_all && (!o_valid || m_ready)) begin
          issue = 1'b1;
          if (rd_off == LAST_OFF) issued_all_n = 1'b1;
          else                    rd_off_n     = rd_off + CW'(1);
        end
      end
      DONE: begin
        state_n    = FILL;
        wr_n       = '0;
        base_n     = '0;
        count_n    = '0;
        frm_n      = '0;
        flushing_n = 1'b0;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_ptr     <= '0;
      base_ptr   <= '0;
      count      <= '0;
      frm_idx    <= '0;
      rd_off     <= '0;
      issued_all <= 1'b0;
      flushing   <= 1'b0;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_zero     <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      base_ptr   <= base_n;
      count      <= count_n;
      frm_idx    <= frm_n;
      rd_off     <= rd_off_n;
      issued_all <= issued_all_n;
      flushing   <= flushing_n;
      if (issue) begin
        o_valid <= 1'b1;
        o_sof   <= (issue_off == '0);
        o_eof   <= (issue_off == LAST_OFF);
        o_zero  <= (issue_off >= count_n);
      end else if (pop) begin
        o_valid <= 1'b0;
      end
    end
  end

  ring_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (s_data),
    .re    (issue),
    .raddr (base_n + AW'(issue_off)),
    .rdata (ram_q)
  );

  // The RAM read register is the output register; offsets past the tail read as zero.
  assign m_valid    = o_valid;
  assign m_sof      = o_valid && o_sof;
  assign m_eof      = o_valid && o_eof;
  assign m_data     = (o_valid && !o_zero) ? ram_q : '0;
  assign flush_done = (state == DONE);

endmodule

// File: tb/tb_frame_ring_buffer.sv
// Self-checking bench for frame_ring_buffer (WIDTH=16, WIN_LENGTH=8, HOP_LENGTH=4).
module tb_frame_ring_buffer;

  localparam int WIDTH = 16;
  localparam int WIN   = 8;
  localparam int HOP   = 4;
  localparam int CW    = 5;
  localparam int FW    = 16;
  localparam int EW    = WIDTH + 2 + FW;

  localparam int RDY_ON   = 0;
  localparam int RDY_OFF  = 1;
  localparam int RDY_RAND = 2;
  localparam int RDY_EXP  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_sof;
  logic             m_eof;
  logic [FW-1:0]    frm_idx;
  logic             flush = 1'b0;
  logic             flush_done;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  int rdy_mode = RDY_ON;
  logic [EW-1:0] exp_q[$];

  frame_ring_buffer #(.WIDTH(WIDTH), .WIN_LENGTH(WIN), .HOP_LENGTH(HOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .frm_idx    (frm_idx),
    .flush      (flush),
    .flush_done (flush_done),
    .count      (count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Downstream ready driver, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        RDY_ON:   m_ready = 1'b1;
        RDY_OFF:  m_ready = 1'b0;
        RDY_RAND: m_ready = 1'($urandom_range(0, 1));
        default:  m_ready = (exp_q.size() != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability
  initial begin
    logic          prev_stall;
    logic [EW-1:0] prev_out;
    logic [EW-1:0] exp;
    logic [EW-1:0] got;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      got = {m_data, m_sof, m_eof, frm_idx};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!m_valid || got != prev_out) begin
            errors++;
            $display("FAIL stall_stable: got valid=%0b data=%0d sof=%0b eof=%0b, required valid=1 data=%0d sof=%0b eof=%0b",
                     m_valid, m_data, m_sof, m_eof, prev_out[EW-1 -: WIDTH], prev_out[FW+1], prev_out[FW]);
          end
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got data=%0d sof=%0b eof=%0b frm=%0d, required no output",
                     m_data, m_sof, m_eof, frm_idx);
          end else begin
            exp = exp_q.pop_front();
            if (got != exp) begin
              errors++;
              $display("FAIL frame_sample: got data=%0d sof=%0b eof=%0b frm=%0d, required data=%0d sof=%0b eof=%0b frm=%0d",
                       m_data, m_sof, m_eof, frm_idx,
                       exp[EW-1 -: WIDTH], exp[FW+1], exp[FW], exp[FW-1:0]);
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_out   = got;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Expected frame: nvalid samples counting up from start, zero padding after.
  task automatic push_frame(input int start, input int nvalid, input int frm);
    logic [WIDTH-1:0] d;
    for (int i = 0; i < WIN; i++) begin
      d = (i < nvalid) ? WIDTH'(start + i) : '0;
      exp_q.push_back({d, (i == 0), (i == WIN - 1), FW'(frm)});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},    32'(s_ready),    1);
    check({tag, "_m_valid"},    32'(m_valid),    0);
    check({tag, "_m_sof"},      32'(m_sof),      0);
    check({tag, "_m_eof"},      32'(m_eof),      0);
    check({tag, "_m_data"},     32'(m_data),     0);
    check({tag, "_flush_done"}, 32'(flush_done), 0);
    check({tag, "_frm_idx"},    32'(frm_idx),    0);
    check({tag, "_count"},      32'(count),      0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    flush   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Driver: hold one sample until accepted, returns just after the accepting edge.
  task automatic write_sample(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: s_ready stayed 0 for sample %0d, required 1", v);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  // Directed stimulus
  initial begin
    int n;

    // Basic framing
    rdy_mode = RDY_ON;
    do_reset();
    push_frame(0, 8, 0);
    push_frame(4, 8, 1);
    for (int i = 0; i < 12; i++) write_sample(WIDTH'(i));
    wait_drain("basic_drain");
    repeat (2) @(negedge clk);
    check("basic_count_after", 32'(count), 4);
    check("basic_frm_after", 32'(frm_idx), 2);

    // Backpressure: ring fills to DEPTH, then releases three intact frames
    rdy_mode = RDY_OFF;
    do_reset();
    push_frame(0, 8, 0);
    push_frame(4, 8, 1);
    push_frame(8, 8, 2);
    for (int i = 0; i < 16; i++) write_sample(WIDTH'(i));
    repeat (2) @(negedge clk);
    check("bp_s_ready_full", 32'(s_ready), 0);
    check("bp_count_full", 32'(count), 16);
    check("bp_stalled_valid", 32'(m_valid), 1);
    check("bp_stalled_sof", 32'(m_sof), 1);
    rdy_mode = RDY_ON;
    wait_drain("bp_drain");
    repeat (2) @(negedge clk);
    check("bp_count_after", 32'(count), 4);
    check("bp_s_ready_after", 32'(s_ready), 1);

    // Random downstream stalls
    rdy_mode = RDY_RAND;
    do_reset();
    push_frame(100, 8, 0);
    push_frame(104, 8, 1);
    for (int i = 0; i < 12; i++) write_sample(WIDTH'(100 + i));
    wait_drain("rand_drain");

    // Flush tail with zero padding
    rdy_mode = RDY_ON;
    do_reset();
    push_frame(0, 8, 0);
    for (int i = 0; i < 10; i++) write_sample(WIDTH'(i));
    wait_drain("flush_pre_drain");
    repeat (3) @(negedge clk);
    check("flush_pre_count", 32'(count), 6);
    push_frame(4, 6, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n = 0;
    while (!flush_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("flush_done_seen", 32'(flush_done), 1);
    check("flush_drained_first", 32'(exp_q.size()), 0);
    check("flush_s_ready_low", 32'(s_ready), 0);
    @(negedge clk);
    check("flush_done_pulse", 32'(flush_done), 0);
    check("flush_count_clear", 32'(count), 0);
    check("flush_frm_clear", 32'(frm_idx), 0);
    check("flush_s_ready_high", 32'(s_ready), 1);

    // Write accepted on the eof cycle of frame 0
    rdy_mode = RDY_ON;
    do_reset();
    push_frame(0, 8, 0);
    for (int i = 0; i < 8; i++) write_sample(WIDTH'(i));
    n = 0;
    while (!(m_valid && m_eof) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sim_eof_seen", 32'(m_valid && m_eof), 1);
    s_valid = 1'b1;
    s_data  = WIDTH'(8);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("sim_count", 32'(count), 5);
    check("sim_frm_idx", 32'(frm_idx), 1);
    wait_drain("sim_drain");

    // Asynchronous reset in the middle of frame 1
    rdy_mode = RDY_EXP;
    do_reset();
    push_frame(0, 8, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back({WIDTH'(4 + i), (i == 0), 1'b0, FW'(1)});
    for (int i = 0; i < 12; i++) write_sample(WIDTH'(i));
    wait_drain("mid_pre_drain");
    repeat (3) @(negedge clk);
    check("mid_stalled_valid", 32'(m_valid), 1);
    check("mid_stalled_data", 32'(m_data), 7);
    check("mid_stalled_frm", 32'(frm_idx), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_async");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = RDY_ON;
    push_frame(0, 8, 0);
    for (int i = 0; i < 8; i++) write_sample(WIDTH'(i));
    @(negedge clk);
    check("lat_cycle1_valid", 32'(m_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(m_valid), 0);
    @(negedge clk);
    check("lat_cycle3_valid", 32'(m_valid), 1);
    check("lat_cycle3_sof", 32'(m_sof), 1);
    wait_drain("post_reset_drain");
    repeat (5) @(negedge clk);
    check("final_count", 32'(count), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
